// File: rtl/ram_arbiter_pkg.sv
// Shared types, encodings and defaults for the two-master RAM arbiter.
// Holds the FSM/owner encodings and the per-master request payload.
package ram_arbiter_pkg;

  localparam int unsigned ADDR_BITS_DEF     = 14;
  localparam int unsigned DMA_BURST_MAX_DEF = 4;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 16;
  localparam int unsigned BURST_W           = 4;
  localparam int unsigned GRANT_CNT_W       = 16;
  localparam int unsigned ERR_CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic              byte_op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] di;
  } mst_req_t;

  // Byte reads pick the addressed lane (odd = high byte) and zero-extend.
  function automatic logic [DATA_W-1:0] read_lane(
    input logic              byte_op,
    input logic              a0,
    input logic [DATA_W-1:0] word
  );
    if (!byte_op) begin
      return word;
    end
    return a0 ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
  endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Winner selection between CPU and DMA with a DMA burst limiter.
// DMA wins by default; after DMA_BURST_MAX DMA grants against a waiting CPU, CPU is forced.
module ram_arbiter_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DMA_BURST_MAX = DMA_BURST_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   idle,
  input  logic   grant,
  output logic   grant_valid_c,
  output owner_t grant_owner_c
);

  logic [BURST_W-1:0] burst_cnt;
  logic               force_cpu_c;

  assign force_cpu_c   = cpu_req && (burst_cnt == BURST_W'(DMA_BURST_MAX));
  assign grant_valid_c = cpu_req || dma_req;
  assign grant_owner_c = (dma_req && !force_cpu_c) ? OWN_DMA : OWN_CPU;

  // Counts DMA grants made while the CPU is kept waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (idle) begin
      if (!cpu_req) begin
        burst_cnt <= '0;
      end else if (grant) begin
        if (grant_owner_c == OWN_CPU) begin
          burst_cnt <= '0;
        end else if (burst_cnt != BURST_W'(DMA_BURST_MAX)) begin
          burst_cnt <= burst_cnt + BURST_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master (CPU/DMA) arbiter and one-cycle sequencer for the byte-capable static RAM.
// Optional RAM_ARB_STATS_EN adds saturating grant/error counters; RAM_DO is taken as the full addressed word.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = ADDR_BITS_DEF,
  parameter int unsigned DMA_BURST_MAX = DMA_BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_di,
  output logic [DATA_W-1:0] cpu_do,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_byte,
  input  logic [ADDR_W-1:0] dma_a,
  input  logic [DATA_W-1:0] dma_di,
  output logic [DATA_W-1:0] dma_do,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic              ram_byte_op
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [GRANT_CNT_W-1:0] cpu_grants,
  output logic [GRANT_CNT_W-1:0] dma_grants,
  output logic [ERR_CNT_W-1:0]   err_count
`endif
);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              cmd_we, cmd_we_nxt;
  logic [DATA_W-1:0] cpu_do_nxt, dma_do_nxt;
  logic              cpu_ack_nxt, cpu_err_nxt, dma_ack_nxt, dma_err_nxt;
  logic [ADDR_W-1:0] ram_a_nxt;
  logic [DATA_W-1:0] ram_di_nxt;
  logic              ram_ce_n_nxt, ram_we_n_nxt, ram_byte_op_nxt;

  mst_req_t          cpu_in, dma_in, sel_in;
  logic              grant_valid_c;
  owner_t            grant_owner_c;
  logic              idle_c, enter_c, sel_err_c, owner_req_c;

  assign cpu_in      = '{we: cpu_we, byte_op: cpu_byte, a: cpu_a, di: cpu_di};
  assign dma_in      = '{we: dma_we, byte_op: dma_byte, a: dma_a, di: dma_di};
  assign sel_in      = (grant_owner_c == OWN_DMA) ? dma_in : cpu_in;
  assign sel_err_c   = |(sel_in.a >> ADDR_BITS);
  assign idle_c      = (state == ST_IDLE);
  assign enter_c     = idle_c && grant_valid_c;
  assign owner_req_c = (owner == OWN_DMA) ? dma_req : cpu_req;

  ram_arbiter_pick #(
    .DMA_BURST_MAX(DMA_BURST_MAX)
  ) u_pick (
    .clk          (clk),
    .rst_n        (reset_n),
    .cpu_req      (cpu_req),
    .dma_req      (dma_req),
    .idle         (idle_c),
    .grant        (enter_c),
    .grant_valid_c(grant_valid_c),
    .grant_owner_c(grant_owner_c)
  );

  // State and all registered outputs; RAM strobes return inactive at once on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      cmd_we      <= 1'b0;
      cpu_do      <= '0;
      dma_do      <= '0;
      cpu_ack     <= 1'b0;
      cpu_err     <= 1'b0;
      dma_ack     <= 1'b0;
      dma_err     <= 1'b0;
      ram_a       <= '0;
      ram_di      <= '0;
      ram_ce_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_byte_op <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      cmd_we      <= cmd_we_nxt;
      cpu_do      <= cpu_do_nxt;
      dma_do      <= dma_do_nxt;
      cpu_ack     <= cpu_ack_nxt;
      cpu_err     <= cpu_err_nxt;
      dma_ack     <= dma_ack_nxt;
      dma_err     <= dma_err_nxt;
      ram_a       <= ram_a_nxt;
      ram_di      <= ram_di_nxt;
      ram_ce_n    <= ram_ce_n_nxt;
      ram_we_n    <= ram_we_n_nxt;
      ram_byte_op <= ram_byte_op_nxt;
    end
  end

  // Next state and next output values; RAM strobes default inactive.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    cmd_we_nxt      = cmd_we;
    cpu_do_nxt      = cpu_do;
    dma_do_nxt      = dma_do;
    cpu_ack_nxt     = cpu_ack;
    cpu_err_nxt     = cpu_err;
    dma_ack_nxt     = dma_ack;
    dma_err_nxt     = dma_err;
    ram_a_nxt       = ram_a;
    ram_di_nxt      = ram_di;
    ram_ce_n_nxt    = 1'b1;
    ram_we_n_nxt    = 1'b1;
    ram_byte_op_nxt = ram_byte_op;

    case (state)
      ST_IDLE: begin
        if (grant_valid_c) begin
          owner_nxt  = grant_owner_c;
          cmd_we_nxt = sel_in.we;
          if (sel_err_c) begin
            state_nxt = ST_DONE;
            if (grant_owner_c == OWN_DMA) begin
              dma_ack_nxt = 1'b1;
              dma_err_nxt = 1'b1;
            end else begin
              cpu_ack_nxt = 1'b1;
              cpu_err_nxt = 1'b1;
            end
          end else begin
            state_nxt       = ST_ACCESS;
            ram_ce_n_nxt    = 1'b0;
            ram_we_n_nxt    = !sel_in.we;
            ram_a_nxt       = sel_in.byte_op ? sel_in.a : {sel_in.a[ADDR_W-1:1], 1'b0};
            ram_di_nxt      = sel_in.di;
            ram_byte_op_nxt = sel_in.byte_op;
          end
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_DONE;
        if (owner == OWN_DMA) begin
          dma_ack_nxt = 1'b1;
          dma_err_nxt = 1'b0;
          if (!cmd_we) begin
            dma_do_nxt = read_lane(ram_byte_op, ram_a[0], ram_do);
          end
        end else begin
          cpu_ack_nxt = 1'b1;
          cpu_err_nxt = 1'b0;
          if (!cmd_we) begin
            cpu_do_nxt = read_lane(ram_byte_op, ram_a[0], ram_do);
          end
        end
      end
      ST_DONE: begin
        if (!owner_req_c) begin
          state_nxt   = ST_IDLE;
          cpu_ack_nxt = 1'b0;
          cpu_err_nxt = 1'b0;
          dma_ack_nxt = 1'b0;
          dma_err_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef RAM_ARB_STATS_EN
  // Saturating per-owner grant counts (errors included) and total error count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_grants <= '0;
      dma_grants <= '0;
      err_count  <= '0;
    end else if (enter_c) begin
      if (grant_owner_c == OWN_DMA) begin
        if (dma_grants != '1) dma_grants <= dma_grants + GRANT_CNT_W'(1);
      end else begin
        if (cpu_grants != '1) cpu_grants <= cpu_grants + GRANT_CNT_W'(1);
      end
      if (sel_err_c && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end
`endif

endmodule
